// File: rtl/window_3x3_linebuf_pkg.sv
// Shared Canny pipeline constants: default pixel width, default image size and
// the helper that sizes the row/column counters.
package canny_pkg;

    localparam int unsigned PIX_W_DEF      = 8;
    localparam int unsigned IMG_WIDTH_DEF  = 640;
    localparam int unsigned IMG_HEIGHT_DEF = 480;

    // Counter width for a dimension of n positions, never narrower than 1 bit
    function automatic int unsigned f_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned COL_W_DEF = f_cnt_w(IMG_WIDTH_DEF);
    localparam int unsigned ROW_W_DEF = f_cnt_w(IMG_HEIGHT_DEF);

endpackage

// File: rtl/window_3x3_linebuf_if.sv
// Pixel-in / window-out bundle of the 3x3 window stage.
// in_sof exists only when LINEBUF_SOF_SYNC_EN is defined.
interface window_3x3_linebuf_if
    import canny_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF
) ();

    logic             in_valid;
    logic [PIX_W-1:0] in_pixel;
`ifdef LINEBUF_SOF_SYNC_EN
    logic             in_sof;
`endif
    logic             out_valid;
    logic [PIX_W-1:0] p00, p01, p02;
    logic [PIX_W-1:0] p10, p11, p12;
    logic [PIX_W-1:0] p20, p21, p22;
    logic             frame_done;

    // Pixel source side
    modport master (
        output in_valid, in_pixel,
`ifdef LINEBUF_SOF_SYNC_EN
        output in_sof,
`endif
        input  out_valid, frame_done,
        input  p00, p01, p02, p10, p11, p12, p20, p21, p22
    );

    // Window stage side
    modport slave (
        input  in_valid, in_pixel,
`ifdef LINEBUF_SOF_SYNC_EN
        input  in_sof,
`endif
        output out_valid, frame_done,
        output p00, p01, p02, p10, p11, p12, p20, p21, p22
    );

endinterface

// File: rtl/window_3x3_linebuf_line_ram.sv
// One image line of storage: synchronous single write port, asynchronous read.
// Contents are deliberately not reset.
module line_ram #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/window_3x3_linebuf.sv
// Raster-to-3x3-window stage feeding the Gaussian blur. Two line memories hold
// the previous two rows; a registered 3x3 window is flagged only when all nine
// taps are real pixels of the current frame.
// Optional: LINEBUF_SOF_SYNC_EN adds in_sof, which forces the accepted pixel to (0,0).
module window_3x3_linebuf
    import canny_pkg::*;
#(
    parameter int unsigned PIX_W      = PIX_W_DEF,
    parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input logic                 clk,
    input logic                 rst,
    window_3x3_linebuf_if.slave bus
);

    localparam int unsigned COL_W = f_cnt_w(IMG_WIDTH);
    localparam int unsigned ROW_W = f_cnt_w(IMG_HEIGHT);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_accept;
    logic             w_sof;
    logic             w_last_col;
    logic             w_last_row;
    logic [PIX_W-1:0] w_lba;
    logic [PIX_W-1:0] w_lbb;
    logic [PIX_W-1:0] r_win [3][3];
    logic             r_out_valid;
    logic             r_frame_done;

    assign w_accept = bus.in_valid;
`ifdef LINEBUF_SOF_SYNC_EN
    assign w_sof = bus.in_sof;
`else
    assign w_sof = 1'b0;
`endif

    // Effective position of the pixel being accepted; SOF overrides the counters
    assign w_col      = w_sof ? '0 : r_col;
    assign w_row      = w_sof ? '0 : r_row;
    assign w_last_col = (w_col == COL_W'(IMG_WIDTH - 1));
    assign w_last_row = (w_row == ROW_W'(IMG_HEIGHT - 1));

    // LB_A holds row r-1; its old contents age into LB_B (row r-2)
    line_ram #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_WIDTH),
        .AW    (COL_W)
    ) u_lb_a (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_col),
        .i_wdata (bus.in_pixel),
        .i_raddr (w_col),
        .o_rdata (w_lba)
    );

    line_ram #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_WIDTH),
        .AW    (COL_W)
    ) u_lb_b (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_col),
        .i_wdata (w_lba),
        .i_raddr (w_col),
        .o_rdata (w_lbb)
    );

    // Raster position counters, advancing only on accepted pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + ROW_W'(1);
            end else begin
                r_col <= w_col + COL_W'(1);
                r_row <= w_row;
            end
        end
    end

    // Window shift: each row moves left, new right column from lines and input
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lbb;
            r_win[1][2] <= w_lba;
            r_win[2][2] <= bus.in_pixel;
        end
    end

    // Flag only interior windows; pulse frame_done after the last pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_accept && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
            r_frame_done <= w_accept && w_last_row && w_last_col;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.p00 = r_win[0][0];
    assign bus.p01 = r_win[0][1];
    assign bus.p02 = r_win[0][2];
    assign bus.p10 = r_win[1][0];
    assign bus.p11 = r_win[1][1];
    assign bus.p12 = r_win[1][2];
    assign bus.p20 = r_win[2][0];
    assign bus.p21 = r_win[2][1];
    assign bus.p22 = r_win[2][2];

endmodule

// File: tb/tb_window_3x3_linebuf.sv
// Bench for window_3x3_linebuf: a 5x4 instance (A) and a 3x3 instance (B),
// checked against a frame-array model indexed by raster position.
module tb_window_3x3_linebuf;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    window_3x3_linebuf_if #(.PIX_W(8)) bus_a ();
    window_3x3_linebuf_if #(.PIX_W(8)) bus_b ();

    window_3x3_linebuf #(
        .PIX_W      (8),
        .IMG_WIDTH  (5),
        .IMG_HEIGHT (4)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    window_3x3_linebuf #(
        .PIX_W      (8),
        .IMG_WIDTH  (3),
        .IMG_HEIGHT (3)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [71:0] taps_a;
    logic [71:0] taps_b;
    assign taps_a = {bus_a.p00, bus_a.p01, bus_a.p02, bus_a.p10, bus_a.p11, bus_a.p12,
                     bus_a.p20, bus_a.p21, bus_a.p22};
    assign taps_b = {bus_b.p00, bus_b.p01, bus_b.p02, bus_b.p10, bus_b.p11, bus_b.p12,
                     bus_b.p20, bus_b.p21, bus_b.p22};

    // Reference model state per instance
    int          mw [2];
    int          mh [2];
    int          mk [2];
    logic [7:0]  img [2][8][8];
    logic        last_valid [2];
    logic [71:0] last_win [2];
    int          win_cnt [2];
    int          fd_cnt [2];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ov(input int s);
        return (s == 0) ? bus_a.out_valid : bus_b.out_valid;
    endfunction

    function automatic logic get_fd(input int s);
        return (s == 0) ? bus_a.frame_done : bus_b.frame_done;
    endfunction

    function automatic logic [71:0] get_taps(input int s);
        return (s == 0) ? taps_a : taps_b;
    endfunction

    task automatic drive(input int s, input logic v, input logic [7:0] pix, input logic sof);
        if (s == 0) begin
            bus_a.in_valid = v;
            bus_a.in_pixel = pix;
`ifdef LINEBUF_SOF_SYNC_EN
            bus_a.in_sof   = sof;
`endif
        end else begin
            bus_b.in_valid = v;
            bus_b.in_pixel = pix;
`ifdef LINEBUF_SOF_SYNC_EN
            bus_b.in_sof   = sof;
`endif
        end
    endtask

    // One accepted pixel, then check the registered result one cycle later
    task automatic accept(input int s, input logic [7:0] pix, input logic sof);
        int          r;
        int          c;
        logic        ev;
        logic        efd;
        logic [71:0] win;
        @(negedge clk);
        drive(s, 1'b1, pix, sof);
        if (sof) mk[s] = 0;
        r = mk[s] / mw[s];
        c = mk[s] % mw[s];
        img[s][r][c] = pix;
        ev  = (r >= 2) && (c >= 2);
        efd = (mk[s] == mw[s] * mh[s] - 1);
        win = '0;
        if (ev) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win = {win[63:0], img[s][r-2+i][c-2+j]};
                end
            end
        end
        mk[s] = (mk[s] + 1) % (mw[s] * mh[s]);
        @(posedge clk);
        #1;
        drive(s, 1'b0, 8'h00, 1'b0);
        chk("out_valid", 72'(get_ov(s)), 72'(ev));
        chk("frame_done", 72'(get_fd(s)), 72'(efd));
        if (ev) chk("taps", get_taps(s), win);
        if (get_ov(s)) win_cnt[s]++;
        if (get_fd(s)) fd_cnt[s]++;
        last_valid[s] = ev;
        last_win[s]   = win;
    endtask

    task automatic idle(input int s);
        @(posedge clk);
        #1;
        chk("idle_out_valid", 72'(get_ov(s)), 72'd0);
        chk("idle_frame_done", 72'(get_fd(s)), 72'd0);
        if (last_valid[s]) chk("idle_taps_hold", get_taps(s), last_win[s]);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk("rst_out_valid", 72'(get_ov(s)), 72'd0);
            chk("rst_frame_done", 72'(get_fd(s)), 72'd0);
            chk("rst_taps", get_taps(s), 72'd0);
            mk[s]         = 0;
            last_valid[s] = 1'b1;
            last_win[s]   = '0;
        end
    endtask

    // mode 0: 16*row+col contiguous, 1: same with 1-0-1 gaps,
    // 2: random pixels contiguous, 3: random pixels with random gaps
    task automatic send_frame(input int s, input int mode, input logic first_sof);
        logic [7:0] pix;
        for (int k = 0; k < mw[s] * mh[s]; k++) begin
            if (mode < 2) pix = 8'(16 * (k / mw[s]) + (k % mw[s]));
            else          pix = 8'($urandom_range(0, 255));
            accept(s, pix, first_sof && (k == 0));
            if (mode == 1) idle(s);
            if (mode == 3 && $urandom_range(0, 2) == 0) idle(s);
        end
    endtask

    task automatic chk_counts(input string tag, input int s, input int exp_win, input int exp_fd);
        chk({tag, "_windows"}, 72'(win_cnt[s]), 72'(exp_win));
        chk({tag, "_frame_done"}, 72'(fd_cnt[s]), 72'(exp_fd));
        win_cnt[s] = 0;
        fd_cnt[s]  = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        mw[0] = 5; mh[0] = 4;
        mw[1] = 3; mh[1] = 3;
        for (int s = 0; s < 2; s++) begin
            win_cnt[s] = 0;
            fd_cnt[s]  = 0;
        end
        repeat (2) @(posedge clk);
        reset_dut();

        // Basic window, continuous input
        for (int k = 0; k <= 12; k++) accept(0, 8'(16 * (k / 5) + (k % 5)), 1'b0);
        chk("first_window", taps_a, 72'h00_01_02_10_11_12_20_21_22);
        for (int k = 13; k < 20; k++) accept(0, 8'(16 * (k / 5) + (k % 5)), 1'b0);
        chk("last_window", taps_a, 72'h12_13_14_22_23_24_32_33_34);
        chk_counts("basic", 0, 6, 1);

        // Gapped input
        send_frame(0, 1, 1'b0);
        chk_counts("gapped", 0, 6, 1);

        // Back-to-back frames
        send_frame(0, 0, 1'b0);
        send_frame(0, 0, 1'b0);
        chk("b2b_last_window", taps_a, 72'h12_13_14_22_23_24_32_33_34);
        chk_counts("b2b", 0, 12, 2);

        // Reset mid-frame after 9 pixels
        for (int k = 0; k < 9; k++) accept(0, 8'($urandom_range(0, 255)), 1'b0);
        win_cnt[0] = 0;
        fd_cnt[0]  = 0;
        reset_dut();
        send_frame(0, 2, 1'b0);
        chk_counts("after_reset", 0, 6, 1);

`ifdef LINEBUF_SOF_SYNC_EN
        // SOF resync on the 7th pixel of a frame
        for (int k = 0; k < 6; k++) accept(0, 8'(16 * (k / 5) + (k % 5)), 1'b0);
        send_frame(0, 2, 1'b1);
        chk_counts("sof_resync", 0, 6, 1);
`endif

        // Random pixels with random gaps
        send_frame(0, 3, 1'b0);
        send_frame(0, 3, 1'b0);
        chk_counts("random_gapped", 0, 12, 2);

        // Minimum-size image
        send_frame(1, 2, 1'b0);
        idle(1);
        chk_counts("min_size", 1, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_3x3_linebuf.md
# window_3x3_linebuf

- Raster-to-window stage that sits directly upstream of the Gaussian blur in the Canny pipeline.
- Accepts one 8-bit grayscale pixel per `in_valid` cycle in raster order.
- Stores the previous two image rows in line memories and presents a registered 3×3 neighbourhood (`p00`..`p22`) with a qualifying `out_valid` strobe.
- Emits only interior windows, where all nine taps are real pixels; the blur consumes these windows directly.

## Interface

Parameters:
- `PIX_W`, default 8: pixel width in bits.
- `IMG_WIDTH`, default 640: pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, default 480: rows per frame; must be ≥ 3.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: `in_pixel` is accepted this cycle. There is no backpressure.
- `in_pixel`, in, `PIX_W`: raster-order pixel.
- `in_sof`, in, 1: start of frame, qualified by `in_valid`. Present only with `LINEBUF_SOF_SYNC_EN`.
- `out_valid`, out, 1: window taps are valid this cycle.
- `p00`..`p22`, out, `PIX_W` each: window taps. `pRC` = row R, column C; row 0 is the oldest row, column 0 is the leftmost column.
- `frame_done`, out, 1: one-cycle pulse after the last pixel of a frame is accepted.

## Operation

- **Counters:** `col` counts 0..`IMG_WIDTH`-1 and `row` counts 0..`IMG_HEIGHT`-1.
  - Both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - At (`IMG_HEIGHT`-1, `IMG_WIDTH`-1), both wrap to 0 and `frame_done` pulses on the next cycle.
- **Line memories:** LB_A[`col`] holds row r-1 and LB_B[`col`] holds row r-2.
  - Reads are asynchronous at address `col`.
  - On accept: LB_B[`col`] ← LB_A[`col`] and LB_A[`col`] ← `in_pixel`.
- **Window registers:** 3×3. On accept, each row shifts left by one column, and the new right column is loaded:
  - `p02` ← LB_B[`col`]
  - `p12` ← LB_A[`col`]
  - `p22` ← `in_pixel`
- **Output qualification:** `out_valid` is set on the cycle after accepting pixel (r,c) when r ≥ 2 and c ≥ 2. Otherwise it is 0.
  - The window is then centred on (r-1, c-1).
  - `p22` = pixel (r,c) and `p00` = pixel (r-2,c-2).
  - Windows that straddle a row wrap (c < 2) or that use pre-frame line contents (r < 2) are never flagged.
- **Idle cycles:** cycles without `in_valid` hold all state. `out_valid` drops to 0 and the taps hold their values.
- **Output count:** exactly (`IMG_WIDTH`-2)·(`IMG_HEIGHT`-2) `out_valid` pulses per frame.
- **Arithmetic:** none. Pixel data passes through unmodified at `PIX_W` bits. Counter widths are $clog2 of the respective dimension.

## Timing

- **Latency:** 1 cycle from accept to `out_valid` / taps. Throughput is 1 window per clock at full input rate.
- **Reset values:** `out_valid` = 0, `frame_done` = 0, all taps = 0, `col` = `row` = 0.
  - Line memory contents are not reset; stale contents are never flagged valid.
- **Reset mid-frame:** the next accepted pixel is treated as (0,0). No `out_valid` appears until row 2, column 2 of the new frame.
- **Frame boundary:** `frame_done` and the final `out_valid` assert in the same cycle.
  - A pixel of the next frame may be accepted in that cycle, and it is (0,0).

## Configuration

- `LINEBUF_SOF_SYNC_EN` defined:
  - The `in_sof` port exists.
  - An accepted pixel with `in_sof` = 1 is forced to (0,0) regardless of the counters. The counters then continue from (0,1).
  - If a frame is cut short by `in_sof`, `frame_done` is not pulsed for the truncated frame.
- `LINEBUF_SOF_SYNC_EN` undefined:
  - There is no `in_sof` port.
  - Frame position comes solely from the counters.

## Structure

- **Shared package `canny_pkg`:** `PIX_W` default, `IMG_WIDTH`/`IMG_HEIGHT` defaults, and the counter-width constants. These are also used by `gaussian_blur` and later stages.
- **Sub-module `line_ram`:** a single-port-write, async-read memory of `IMG_WIDTH` × `PIX_W`. It is instantiated twice (LB_A, LB_B).
- **Top module:** the counters, the window shift registers and the qualification logic stay here.

## Test plan

- **Basic window:** 5×4 image, pixel = 16·row + col, continuous `in_valid`.
  - First `out_valid` occurs 1 cycle after accepting (2,2), with taps `p00`..`p22` = 00,01,02 / 10,11,12 / 20,21,22 hex.
  - Exactly 6 windows are produced; the last is centred on 0x23.
- **Gapped input:** same image with `in_valid` toggling 1-0-1.
  - The window sequence is identical.
  - `out_valid` never asserts on a cycle after an idle input cycle.
  - Taps hold during gaps.
- **Back-to-back frames:** two 5×4 frames with no gap.
  - `frame_done` pulses once per frame, coincident with the final window (centred on 0x23).
  - Frame 2's first window equals frame 1's.
- **Reset mid-frame:** assert `rst` for 1 cycle after 9 pixels.
  - Outputs are 0 the next cycle.
  - A fresh 5×4 frame then yields exactly 6 correct windows.
- **SOF resync (`LINEBUF_SOF_SYNC_EN`):** pulse `in_sof` on the 7th pixel of frame 1.
  - No `frame_done` for the aborted frame.
  - The restarted frame yields 6 correct windows and one `frame_done`.
- **Minimum size:** 3×3 image produces exactly 1 window, equal to the whole image, plus one `frame_done`.
